count_seq_monitor: RTL and testbench
====================================

COUNT_SEQ_MONITOR -- requirements
Module: count_seq_monitor

Interface
REQ-001 SHALL provide parameter MOD, default 16: modulus of the monitored count sequence, legal range 2..16.
REQ-002 SHALL provide parameter ERR_LIMIT, default 3: consecutive mismatches in SYNC that force LOST, legal range 1..15.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port cnt_in  input  4  count value from the upstream synchronous counter.
REQ-006 SHALL have port cnt_en  input  1  cnt_in is a valid sample this cycle.
REQ-007 SHALL have port state  output  2  FSM state: SEARCH=00, SYNC=01, LOST=10; 11 unused.
REQ-008 SHALL have port in_sync  output  1  high exactly when state is SYNC.
REQ-009 SHALL have port wrap  output  1  one-cycle pulse on a legal MOD-1 -> 0 step in SYNC.
REQ-010 SHALL have port mismatch  output  1  one-cycle pulse on an illegal step in SYNC.
REQ-011 SHALL have port wrap_bcd  output  8  two-digit BCD wrap tally, [7:4] tens, [3:0] units.
REQ-012 SHALL have port err_cnt  output  8  saturating binary count of mismatches.

Function
REQ-013 SHALL register all outputs; response to a sample accepted at edge N appears after edge N, and is visible during cycle N+1.
REQ-014 SHALL define next(p) = 0 when p == MOD-1, else p+1; a step is legal when cnt_in == next(prev) and cnt_in < MOD.
REQ-015 SHALL hold internal prev (4 bit), prev_valid (1 bit), miss (4 bit), good (1 bit).
REQ-016 SHALL, with cnt_en low, hold all state and counters, and drive wrap and mismatch low.
REQ-017 SHALL, in SEARCH or LOST with cnt_en high and cnt_in >= MOD, clear prev_valid and good.
REQ-018 SHALL, in SEARCH with cnt_en high and cnt_in < MOD, load prev <= cnt_in and set prev_valid; go to SYNC when prev_valid was set and the step is legal.
REQ-019 SHALL, in LOST, require two consecutive legal steps: the first sets good, the second enters SYNC; an illegal step clears good; prev reloads from every in-range sample.
REQ-020 SHALL, in SYNC on a legal step, load prev, clear miss, and pulse wrap when prev was MOD-1 and cnt_in is 0.
REQ-021 SHALL, in SYNC on an illegal step (including cnt_in >= MOD), pulse mismatch, increment err_cnt saturating at 255, and increment miss.
REQ-022 SHALL, on an illegal in-range step in SYNC, load prev <= cnt_in, so a single skip costs one mismatch only.
REQ-023 SHALL, on an out-of-range illegal step in SYNC, leave prev unchanged.
REQ-024 SHALL enter LOST, with good cleared, when miss reaches ERR_LIMIT.
REQ-025 SHALL NOT generate wrap or mismatch outside SYNC; the transition into SYNC itself produces no wrap pulse, even on MOD-1 -> 0.
REQ-026 SHALL increment wrap_bcd in BCD on each wrap pulse, 09 -> 10, 99 -> 00; the units digit never exceeds 9.
REQ-027 SHALL retain err_cnt and wrap_bcd across SEARCH/SYNC/LOST transitions; only reset clears them.

Reset
REQ-028 SHALL, on reset high at a clock edge, set state SEARCH, prev 0, prev_valid 0, miss 0, good 0, wrap 0, mismatch 0, wrap_bcd 00, err_cnt 0.
REQ-029 SHALL give reset priority over cnt_en in the same cycle; reset mid-sequence discards the sample.
REQ-030 SHALL need no initial-value statements for correct behaviour after the first reset.

Verification
REQ-031 Lock: MOD=16, reset, then cnt_en=1 with cnt_in 5,6 -> state SEARCH after 5, SYNC after 6, in_sync=1, no pulses.
REQ-032 Wrap/BCD: in SYNC, feed 0..15 repeatedly for 100 wraps -> wrap pulses exactly once per 15->0; wrap_bcd passes 09->10 and 99->00.
REQ-033 Skip/limit: in SYNC, feed 3,4,7,8 -> one mismatch at 7, err_cnt=1, stays SYNC; then feed 9,2,11,5 with ERR_LIMIT=3 -> LOST after third consecutive miss.
REQ-034 Relock and MOD: MOD=10 in LOST, feed 9,0,1 -> SYNC after 1, no wrap; cnt_in=12 in SYNC -> mismatch, prev unchanged.
REQ-035 Hold and reset: cnt_en low for 20 cycles -> outputs frozen; reset asserted with cnt_en=1 -> all REQ-028 values next cycle.
REQ-036 Saturation: force 300 mismatches -> err_cnt holds 255.

Source files
------------

// File: rtl/count_seq_monitor.sv
// Monitors an upstream modulo-MOD counter. It locks onto the count sequence, flags
// skipped or out-of-range values, drops lock after ERR_LIMIT consecutive misses, and tallies wraps.
module count_seq_monitor #(
    parameter int MOD       = 16,
    parameter int ERR_LIMIT = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cnt_in,
    input  logic       cnt_en,
    output logic [1:0] state,
    output logic       in_sync,
    output logic       wrap,
    output logic       mismatch,
    output logic [7:0] wrap_bcd,
    output logic [7:0] err_cnt
);

    typedef enum logic [1:0] {
        SEARCH = 2'b00,
        SYNC   = 2'b01,
        LOST   = 2'b10
    } state_t;

    localparam logic [4:0] MOD_W = 5'(MOD);
    localparam logic [3:0] LAST  = 4'(MOD - 1);
    localparam logic [3:0] LIMIT = 4'(ERR_LIMIT);

    state_t     cur_state, nxt_state;
    logic [3:0] prev, prev_nxt;
    logic       prev_valid, prev_valid_nxt;
    logic [3:0] miss, miss_nxt, miss_inc;
    logic       good, good_nxt;
    logic       wrap_nxt, mismatch_nxt;
    logic       err_inc, tally_inc;
    logic       in_range, legal;
    logic [3:0] expected;

    // Two-digit BCD increment; the tens digit rolls 9 -> 0 so the tally wraps 99 -> 00.
    function automatic logic [7:0] bcd_next(input logic [7:0] v);
        logic [7:0] r;
        r = v;
        if (v[3:0] >= 4'd9) begin
            r[3:0] = 4'd0;
            r[7:4] = (v[7:4] >= 4'd9) ? 4'd0 : v[7:4] + 4'd1;
        end else begin
            r[3:0] = v[3:0] + 4'd1;
        end
        return r;
    endfunction

    assign in_range = {1'b0, cnt_in} < MOD_W;
    assign expected = (prev == LAST) ? 4'd0 : prev + 4'd1;
    assign legal    = prev_valid && in_range && (cnt_in == expected);
    assign miss_inc = miss + 4'd1;

    // NOTE: every signal assigned here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        nxt_state      = cur_state;
        prev_nxt       = prev;
        prev_valid_nxt = prev_valid;
        miss_nxt       = miss;
        good_nxt       = good;
        wrap_nxt       = 1'b0;
        mismatch_nxt   = 1'b0;
        err_inc        = 1'b0;
        tally_inc      = 1'b0;

        if (cnt_en) begin
            unique case (cur_state)
                SEARCH: begin
                    if (!in_range) begin
                        prev_valid_nxt = 1'b0;
                        good_nxt       = 1'b0;
                    end else begin
                        prev_nxt       = cnt_in;
                        prev_valid_nxt = 1'b1;
                        if (legal) begin
                            nxt_state = SYNC;
                            miss_nxt  = 4'd0;
                            good_nxt  = 1'b0;
                        end
                    end
                end

                LOST: begin
                    if (!in_range) begin
                        prev_valid_nxt = 1'b0;
                        good_nxt       = 1'b0;
                    end else begin
                        prev_nxt       = cnt_in;
                        prev_valid_nxt = 1'b1;
                        if (!legal) begin
                            good_nxt = 1'b0;
                        end else if (good) begin
                            nxt_state = SYNC;
                            miss_nxt  = 4'd0;
                            good_nxt  = 1'b0;
                        end else begin
                            good_nxt = 1'b1;
                        end
                    end
                end

                SYNC: begin
                    if (legal) begin
                        prev_nxt = cnt_in;
                        miss_nxt = 4'd0;
                        if (prev == LAST) begin
                            wrap_nxt  = 1'b1;
                            tally_inc = 1'b1;
                        end
                    end else begin
                        mismatch_nxt = 1'b1;
                        err_inc      = 1'b1;
                        miss_nxt     = miss_inc;
                        // Resync on an in-range skip so one skip costs a single mismatch.
                        if (in_range) prev_nxt = cnt_in;
                        if (miss_inc >= LIMIT) begin
                            nxt_state = LOST;
                            good_nxt  = 1'b0;
                        end
                    end
                end

                default: nxt_state = SEARCH;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (reset) cur_state <= SEARCH;
        else       cur_state <= nxt_state;
    end

    assign state = cur_state;

    always_ff @(posedge clk) begin
        if (reset) begin
            prev       <= 4'd0;
            prev_valid <= 1'b0;
            miss       <= 4'd0;
            good       <= 1'b0;
            in_sync    <= 1'b0;
            wrap       <= 1'b0;
            mismatch   <= 1'b0;
            wrap_bcd   <= 8'h00;
            err_cnt    <= 8'd0;
        end else begin
            prev       <= prev_nxt;
            prev_valid <= prev_valid_nxt;
            miss       <= miss_nxt;
            good       <= good_nxt;
            in_sync    <= (nxt_state == SYNC);
            wrap       <= wrap_nxt;
            mismatch   <= mismatch_nxt;
            if (tally_inc)                     wrap_bcd <= bcd_next(wrap_bcd);
            if (err_inc && err_cnt != 8'hFF)   err_cnt  <= err_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_count_seq_monitor.sv
// Self-checking bench: two monitors (MOD=16/LIMIT=3, MOD=10/LIMIT=2) compared every
// cycle against an arithmetic model, plus directed scenarios with literal expectations.
module tb_count_seq_monitor;

    logic       clk;
    logic       rst_v [2];
    logic       en_v  [2];
    logic [3:0] cin_v [2];
    logic [1:0] st    [2];
    logic       insy  [2];
    logic       wr    [2];
    logic       mis   [2];
    logic [7:0] bcd   [2];
    logic [7:0] errc  [2];

    int checks = 0;
    int errors = 0;

    count_seq_monitor #(.MOD(16), .ERR_LIMIT(3)) dut16 (
        .clk(clk), .reset(rst_v[0]), .cnt_in(cin_v[0]), .cnt_en(en_v[0]),
        .state(st[0]), .in_sync(insy[0]), .wrap(wr[0]), .mismatch(mis[0]),
        .wrap_bcd(bcd[0]), .err_cnt(errc[0])
    );

    count_seq_monitor #(.MOD(10), .ERR_LIMIT(2)) dut10 (
        .clk(clk), .reset(rst_v[1]), .cnt_in(cin_v[1]), .cnt_en(en_v[1]),
        .state(st[1]), .in_sync(insy[1]), .wrap(wr[1]), .mismatch(mis[1]),
        .wrap_bcd(bcd[1]), .err_cnt(errc[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: state 0=SEARCH 1=SYNC 2=LOST, wrap tally kept as a plain 0..99 integer.
    typedef struct {
        bit valid;
        int st;
        int prev;
        bit pv;
        int miss;
        bit good;
        bit wrap;
        bit mis;
        int tally;
        int errs;
    } model_t;

    model_t mdl [2];

    function automatic model_t model_next(model_t m, int md, int lim,
                                          logic r, logic e, logic [3:0] c);
        model_t n;
        int     ci;
        bit     inr;
        bit     lg;
        n      = m;
        n.wrap = 1'b0;
        n.mis  = 1'b0;
        if (r) begin
            n.valid = 1'b1; n.st = 0; n.prev = 0; n.pv = 1'b0; n.miss = 0;
            n.good = 1'b0; n.tally = 0; n.errs = 0;
            return n;
        end
        if (!e) return n;
        ci  = int'(c);
        inr = ci < md;
        lg  = m.pv && inr && (ci == (m.prev + 1) % md);
        if (m.st == 1) begin
            if (lg) begin
                n.prev = ci; n.miss = 0;
                if (m.prev == md - 1) begin
                    n.wrap  = 1'b1;
                    n.tally = (m.tally + 1) % 100;
                end
            end else begin
                n.mis  = 1'b1;
                n.errs = (m.errs < 255) ? m.errs + 1 : 255;
                n.miss = m.miss + 1;
                if (inr) n.prev = ci;
                if (n.miss >= lim) begin
                    n.st = 2; n.good = 1'b0;
                end
            end
        end else if (!inr) begin
            n.pv = 1'b0; n.good = 1'b0;
        end else begin
            n.prev = ci; n.pv = 1'b1;
            if (m.st == 0) begin
                if (lg) begin
                    n.st = 1; n.miss = 0;
                end
            end else if (!lg) begin
                n.good = 1'b0;
            end else if (m.good) begin
                n.st = 1; n.miss = 0; n.good = 1'b0;
            end else begin
                n.good = 1'b1;
            end
        end
        return n;
    endfunction

    always @(posedge clk) begin
        mdl[0] <= model_next(mdl[0], 16, 3, rst_v[0], en_v[0], cin_v[0]);
        mdl[1] <= model_next(mdl[1], 10, 2, rst_v[1], en_v[1], cin_v[1]);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (mdl[i].valid) begin
                check($sformatf("dut%0d state", i), 32'(st[i]), 32'(mdl[i].st));
                check($sformatf("dut%0d in_sync", i), 32'(insy[i]), 32'(mdl[i].st == 1));
                check($sformatf("dut%0d wrap", i), 32'(wr[i]), 32'(mdl[i].wrap));
                check($sformatf("dut%0d mismatch", i), 32'(mis[i]), 32'(mdl[i].mis));
                check($sformatf("dut%0d wrap_bcd", i), 32'(bcd[i]),
                      32'(((mdl[i].tally / 10) << 4) | (mdl[i].tally % 10)));
                check($sformatf("dut%0d err_cnt", i), 32'(errc[i]), 32'(mdl[i].errs));
            end
        end
    end

    // Apply one sample to monitor i at a falling edge; returns at the next falling edge,
    // by which time the response is visible.
    task automatic drive(input int i, input logic r, input logic e, input logic [3:0] c);
        rst_v[i] = r;
        en_v[i]  = e;
        cin_v[i] = c;
        @(negedge clk);
    endtask

    task automatic feed(input int i, input logic [3:0] c);
        drive(i, 1'b0, 1'b1, c);
    endtask

    int wraps_seen;
    int p;

    initial begin
        for (int i = 0; i < 2; i++) begin
            rst_v[i] = 1'b1; en_v[i] = 1'b0; cin_v[i] = 4'd0;
        end
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            rst_v[i] = 1'b0;
            check("reset state", 32'(st[i]), 32'd0);
            check("reset in_sync", 32'(insy[i]), 32'd0);
            check("reset wrap_bcd", 32'(bcd[i]), 32'h00);
            check("reset err_cnt", 32'(errc[i]), 32'd0);
        end

        // Lock on 5,6.
        feed(0, 4'd5);
        check("lock after 5 state", 32'(st[0]), 32'd0);
        feed(0, 4'd6);
        check("lock after 6 state", 32'(st[0]), 32'd1);
        check("lock in_sync", 32'(insy[0]), 32'd1);
        check("lock no wrap", 32'(wr[0]), 32'd0);
        check("lock no mismatch", 32'(mis[0]), 32'd0);

        // 100 wraps through the full 0..15 sequence.
        for (int v = 7; v < 16; v++) feed(0, 4'(v));
        wraps_seen = 0;
        for (int w = 1; w <= 100; w++) begin
            for (int v = 0; v < 16; v++) begin
                feed(0, 4'(v));
                check("wrap pulse", 32'(wr[0]), 32'(v == 0));
                if (wr[0] === 1'b1) wraps_seen++;
            end
            if (w == 9)   check("bcd 09", 32'(bcd[0]), 32'h09);
            if (w == 10)  check("bcd 10", 32'(bcd[0]), 32'h10);
            if (w == 99)  check("bcd 99", 32'(bcd[0]), 32'h99);
            if (w == 100) check("bcd 00", 32'(bcd[0]), 32'h00);
        end
        check("wrap total", 32'(wraps_seen), 32'd100);

        // Single skip, then three consecutive misses.
        feed(0, 4'd0); feed(0, 4'd1); feed(0, 4'd2);
        feed(0, 4'd3); feed(0, 4'd4);
        feed(0, 4'd7);
        check("skip mismatch", 32'(mis[0]), 32'd1);
        check("skip err_cnt", 32'(errc[0]), 32'd1);
        check("skip stays sync", 32'(st[0]), 32'd1);
        feed(0, 4'd8);
        check("after skip no mismatch", 32'(mis[0]), 32'd0);
        feed(0, 4'd9); feed(0, 4'd2); feed(0, 4'd11);
        check("two misses still sync", 32'(st[0]), 32'd1);
        feed(0, 4'd5);
        check("third miss lost", 32'(st[0]), 32'd2);
        check("lost err_cnt", 32'(errc[0]), 32'd4);
        check("lost wrap_bcd", 32'(bcd[0]), 32'h01);

        // Hold with cnt_en low.
        for (int k = 0; k < 20; k++) drive(0, 1'b0, 1'b0, 4'(k));
        check("hold state", 32'(st[0]), 32'd2);
        check("hold err_cnt", 32'(errc[0]), 32'd4);
        check("hold wrap_bcd", 32'(bcd[0]), 32'h01);
        check("hold pulses", 32'({wr[0], mis[0]}), 32'd0);

        // Second monitor (modulus 10): lock, lose, relock via 9,0,1.
        feed(1, 4'd3); feed(1, 4'd4);
        check("m10 lock", 32'(st[1]), 32'd1);
        feed(1, 4'd7); feed(1, 4'd1);
        check("m10 lost", 32'(st[1]), 32'd2);
        feed(1, 4'd9);
        feed(1, 4'd0);
        check("m10 one good step", 32'(st[1]), 32'd2);
        feed(1, 4'd1);
        check("m10 relock", 32'(st[1]), 32'd1);
        check("m10 relock no wrap", 32'(wr[1]), 32'd0);
        feed(1, 4'd12);
        check("m10 out of range mismatch", 32'(mis[1]), 32'd1);
        check("m10 err_cnt", 32'(errc[1]), 32'd3);
        feed(1, 4'd2);
        check("m10 prev kept", 32'(mis[1]), 32'd0);
        for (int v = 3; v < 10; v++) feed(1, 4'(v));
        feed(1, 4'd0);
        check("m10 wrap at 9->0", 32'(wr[1]), 32'd1);
        check("m10 wrap_bcd", 32'(bcd[1]), 32'h01);

        // Saturation: legal step then out-of-range, 300 times.
        p = 0;
        for (int k = 0; k < 300; k++) begin
            p = (p + 1) % 10;
            feed(1, 4'(p));
            feed(1, 4'd15);
        end
        check("saturated err_cnt", 32'(errc[1]), 32'd255);
        check("saturated still sync", 32'(st[1]), 32'd1);

        // Reset wins over a valid sample.
        drive(0, 1'b1, 1'b1, 4'd5);
        check("rst state", 32'(st[0]), 32'd0);
        check("rst pulses", 32'({insy[0], wr[0], mis[0]}), 32'd0);
        check("rst wrap_bcd", 32'(bcd[0]), 32'h00);
        check("rst err_cnt", 32'(errc[0]), 32'd0);
        feed(0, 4'd15);
        check("sample after reset not paired", 32'(st[0]), 32'd0);
        feed(0, 4'd0);
        check("lock on 15->0", 32'(st[0]), 32'd1);
        check("no wrap on lock", 32'(wr[0]), 32'd0);

        // Randomized phase on both monitors.
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 2; i++) begin
                int md;
                int r;
                md = (i == 0) ? 16 : 10;
                r  = int'($urandom_range(0, 99));
                rst_v[i] = ($urandom_range(0, 299) == 0);
                en_v[i]  = ($urandom_range(0, 7) != 0);
                if (r < 70)      cin_v[i] = 4'((mdl[i].prev + 1) % md);
                else             cin_v[i] = 4'($urandom_range(0, 15));
            end
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
